calc_engine: RTL
================

// Module: calc_engine
// PURPOSE
//  Calculator datapath/controller directly downstream of the keypad interpreter. Consumes its
//  single-cycle strobes (newhex/hexcode, newop/opcode, eq, BS). Builds hex operands, latches
//  operators and evaluates chained binary expressions. Drives the value to show on the display.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; multiple of 4 (WIDTH/4 hex digits)
// PORTS
//  clk      in   1      system clock; all state changes on rising edge
//  rst_n    in   1      reset: synchronous, active-low
//  newhex   in   1      1-cycle strobe, hex digit key pressed
//  hexcode  in   4      digit value, valid with newhex
//  newop    in   1      1-cycle strobe, non-hex key pressed (also high with eq/BS keys)
//  opcode   in   2      00 add, 01 multiply, 10 subtract, 11 treated as add
//  eq       in   1      1-cycle strobe, equals key
//  BS       in   1      1-cycle strobe, backspace key
//  display  out  WIDTH  registered value to show
//  ovf      out  1      registered overflow flag of last evaluation
//  pending  out  1      high while an operator is latched (state OP_PEND or ENTER_B)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge, wins over all strobes, also mid-operation): state ENTER_A;
//    cur, acc, lastb, op, display all 0; ovf=0; pending=0.
//  - Strobe priority per cycle: eq > BS > newhex > newop; newop ignored when eq or BS high.
//  - All outputs update the cycle after the strobe (1-cycle latency). No strobe: hold.
//  - States: ENTER_A, OP_PEND, ENTER_B, RESULT. display = cur in ENTER_A/ENTER_B, acc in OP_PEND,
//    res in RESULT.
//  - Digit entry: cur <= {cur[WIDTH-5:0],hexcode} only if cur[WIDTH-1:WIDTH-4]==0, else dropped.
//    In ENTER_A/ENTER_B: append to cur. OP_PEND: cur<=hexcode, ->ENTER_B.
//    RESULT: cur<=hexcode, ovf<=0, ->ENTER_A (new expression).
//  - BS: ENTER_A/ENTER_B: cur <= cur>>4 (0 stays 0). OP_PEND: cancel operator, cur<=acc, ->ENTER_A.
//    RESULT: cur<=res>>4, ovf<=0, ->ENTER_A.
//  - newop: ENTER_A: acc<=cur, op<=opcode, ->OP_PEND. OP_PEND: op replaced.
//    ENTER_B: acc<=acc op cur (chained), ovf updated, op<=opcode, ->OP_PEND.
//    RESULT: acc<=res, op<=opcode, ->OP_PEND.
//  - eq: ENTER_B: res<=acc op cur, lastb<=cur, ovf updated, ->RESULT. ENTER_A/OP_PEND: no effect.
//    RESULT: see CONFIGURATION.
//  - Arithmetic mod 2^WIDTH, unsigned. ovf: add -> carry out; sub -> borrow (a<b);
//    mul -> any nonzero bit in upper WIDTH of the 2*WIDTH product.
// CONFIGURATION
//  CALC_REPEAT_EQ_EN defined: eq in RESULT applies res<=res op lastb, ovf updated (repeat last op).
//  Not defined: eq in RESULT has no effect; lastb register may be omitted.
// STRUCTURE
//  calc_pkg: opcode constants (OP_ADD/OP_MUL/OP_SUB), state enum encoding, digit-width constant.
//  Sub-module calc_alu: combinational, inputs a,b,op; outputs y[WIDTH-1:0], ovf. One instance,
//  operand mux selects acc/cur vs res/lastb.
// TESTING  (WIDTH=16; hex digits as newhex strobes)
//  - rst_n=0 one edge mid-entry -> display=0000, ovf=0, pending=0, state ENTER_A.
//  - 1,2,3,BS -> 0012; then 4,5,6 -> 1245, digit 6 dropped.
//  - 1,2,+,3,4,= -> pending 1 after +, display 0034 then 0046, ovf=0, pending=0.
//  - F,F,F,F,+,1,= -> 0000 ovf=1; 3,-,5,= -> FFFE ovf=1; 1,0,0,*,1,0,0,= -> 0000 ovf=1.
//  - 2,*,3,+ -> display 0006; 4,= -> 000A. eq and newop same cycle -> eq only.
//  - 2,+,3,=,= -> 0005 then 0008 with CALC_REPEAT_EQ_EN; stays 0005 without.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared opcodes, FSM state encoding and digit width for the calculator engine
package calc_pkg;
  localparam int DIG = 4;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  typedef enum logic [1:0] {ENTER_A, OP_PEND, ENTER_B, RESULT} state_t;
endpackage

// File: rtl/calc_alu.sv
// calc_alu: combinational unsigned add/mul/sub mod 2^WIDTH with overflow (carry/borrow/high product bits); ports a,b,op in, y,ovf out
module calc_alu import calc_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    prod = a * b;
    y    = op == OP_MUL ? prod[WIDTH-1:0] : op == OP_SUB ? a - b : sum[WIDTH-1:0];
    ovf  = op == OP_MUL ? |prod[2*WIDTH-1:WIDTH] : op == OP_SUB ? a < b : sum[WIDTH];
  end
endmodule

// File: rtl/calc_engine.sv
// calc_engine: keypad-driven hex calculator controller; builds operands, chains binary ops, drives display
// in: clk, rst_n (sync, active-low), newhex/hexcode, newop/opcode, eq, BS; out: display, ovf, pending
// CALC_REPEAT_EQ_EN: eq in RESULT repeats the last operation with the last right operand
module calc_engine import calc_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             newhex,
  input  logic [3:0]       hexcode,
  input  logic             newop,
  input  logic [1:0]       opcode,
  input  logic             eq,
  input  logic             BS,
  output logic [WIDTH-1:0] display,
  output logic             ovf,
  output logic             pending
);
  state_t state, state_n;
  logic [WIDTH-1:0] cur, cur_n, acc, acc_n, res, res_n, app, hexw, alu_a, alu_b, alu_y;
  logic [1:0] op, op_n;
  logic ovf_n, alu_ovf;
`ifdef CALC_REPEAT_EQ_EN
  logic [WIDTH-1:0] lastb, lastb_n;
  // once a result is shown, the ALU replays res op lastb for repeated equals
  assign alu_a = state == RESULT ? res : acc;
  assign alu_b = state == RESULT ? lastb : cur;
`else
  assign alu_a = acc;
  assign alu_b = cur;
`endif
  assign hexw = {{(WIDTH-DIG){1'b0}}, hexcode};
  // a full operand silently drops further digits
  assign app = cur[WIDTH-1:WIDTH-DIG] == '0 ? {cur[WIDTH-DIG-1:0], hexcode} : cur;
  calc_alu #(.WIDTH(WIDTH)) u_alu (.a(alu_a), .b(alu_b), .op(op), .y(alu_y), .ovf(alu_ovf));
  always_comb begin
    state_n = state;
    cur_n   = cur;
    acc_n   = acc;
    res_n   = res;
    op_n    = op;
    ovf_n   = ovf;
`ifdef CALC_REPEAT_EQ_EN
    lastb_n = lastb;
`endif
    if (eq) begin
      if (state == ENTER_B) begin
        res_n   = alu_y;
        ovf_n   = alu_ovf;
        state_n = RESULT;
`ifdef CALC_REPEAT_EQ_EN
        lastb_n = cur;
`endif
      end
`ifdef CALC_REPEAT_EQ_EN
      else if (state == RESULT) begin
        res_n = alu_y;
        ovf_n = alu_ovf;
      end
`endif
    end else if (BS) begin
      case (state)
        OP_PEND: begin cur_n = acc; state_n = ENTER_A; end
        RESULT:  begin cur_n = res >> DIG; ovf_n = 1'b0; state_n = ENTER_A; end
        default: cur_n = cur >> DIG;
      endcase
    end else if (newhex) begin
      case (state)
        OP_PEND: begin cur_n = hexw; state_n = ENTER_B; end
        RESULT:  begin cur_n = hexw; ovf_n = 1'b0; state_n = ENTER_A; end
        default: cur_n = app;
      endcase
    end else if (newop) begin
      op_n    = opcode;
      state_n = OP_PEND;
      case (state)
        ENTER_A: acc_n = cur;
        ENTER_B: begin acc_n = alu_y; ovf_n = alu_ovf; end
        RESULT:  acc_n = res;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state   <= ENTER_A;
      cur     <= '0;
      acc     <= '0;
      res     <= '0;
      op      <= OP_ADD;
      ovf     <= 1'b0;
      display <= '0;
      pending <= 1'b0;
`ifdef CALC_REPEAT_EQ_EN
      lastb   <= '0;
`endif
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      acc     <= acc_n;
      res     <= res_n;
      op      <= op_n;
      ovf     <= ovf_n;
      display <= state_n == OP_PEND ? acc_n : state_n == RESULT ? res_n : cur_n;
      pending <= state_n == OP_PEND || state_n == ENTER_B;
`ifdef CALC_REPEAT_EQ_EN
      lastb   <= lastb_n;
`endif
    end
endmodule
